// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the pipeline memory-access stage.
package mem_stage_pkg;

  localparam int unsigned WordAddrW      = 30;
  localparam int unsigned RegIdxW        = 5;
  localparam int unsigned CountW         = 8;
  localparam int unsigned TimeoutDefault = 15;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory request FSM with watchdog: issues one access, waits for ready or aborts.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned Timeout = TimeoutDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [WordAddrW-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic                 dm_ready_i,
  output logic                 done_o,
  output logic                 abort_o,
  output logic                 dm_req_o,
  output logic                 dm_we_o,
  output logic [WordAddrW-1:0] dm_addr_o,
  output logic [31:0]          dm_wdata_o,
  output logic                 dm_err_o
);

  localparam logic [CountW-1:0] TimeoutCnt = CountW'(Timeout);

  mem_state_e           state_q, state_d;
  logic [CountW-1:0]    count_q, count_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [WordAddrW-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 busy;
  logic                 timeout_hit;

  assign busy        = (state_q == StBusy);
  assign timeout_hit = (count_q == TimeoutCnt);
  assign done_o      = busy & dm_ready_i;
  // Ready on the final watchdog cycle still counts as a normal completion.
  assign abort_o     = busy & ~dm_ready_i & timeout_hit;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StBusy;
          count_d = '0;
          req_d   = 1'b1;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      StBusy: begin
        if (dm_ready_i) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = StIdle;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign dm_req_o   = req_q;
  assign dm_we_o    = we_q;
  assign dm_addr_o  = addr_q;
  assign dm_wdata_o = wdata_q;
  assign dm_err_o   = err_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: branch redirect, data-memory access with stall, MEM/WB register.
// Optional overflow suppression and ovf_trap output enabled by MEM_STAGE_OVF_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          Addr_in,
  input  logic [31:0]          Di_in,
  input  logic [RegIdxW-1:0]   Rw_in,
  input  logic                 MemWr,
  input  logic                 MemtoReg,
  input  logic                 RegWr,
  input  logic                 Branch,
  input  logic                 Jump,
  input  logic                 Zero,
  input  logic                 Overflow,
  input  logic [WordAddrW-1:0] Btarg,
  input  logic [WordAddrW-1:0] Jtarg,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [WordAddrW-1:0] dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata,
  input  logic                 dm_ready,
  output logic                 stall,
  output logic                 pc_redirect,
  output logic [WordAddrW-1:0] pc_target,
  output logic                 dm_err,
`ifdef MEM_STAGE_OVF_TRAP_EN
  output logic                 ovf_trap,
`endif
  output logic                 wb_valid,
  output logic [31:0]          Do_out,
  output logic [31:0]          Alu_out,
  output logic [RegIdxW-1:0]   Rw_out,
  output logic                 MemtoReg_out,
  output logic                 RegWr_out
);

  logic trap;
  logic memop;
  logic acc_done;
  logic acc_abort;

`ifdef MEM_STAGE_OVF_TRAP_EN
  assign trap = in_valid & Overflow;
`else
  logic unused_overflow;
  assign unused_overflow = Overflow;
  assign trap            = 1'b0;
`endif

  assign memop       = in_valid & (MemWr | MemtoReg) & ~trap;
  assign stall       = memop & ~(acc_done | acc_abort);
  assign pc_redirect = in_valid & ~trap & (Jump | (Branch & Zero));
  assign pc_target   = Jump ? Jtarg : Btarg;

  mem_access_fsm #(
    .Timeout(TIMEOUT)
  ) u_fsm (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (memop),
    .we_i      (MemWr & ~MemtoReg),
    .addr_i    (Addr_in[31:2]),
    .wdata_i   (Di_in),
    .dm_ready_i(dm_ready),
    .done_o    (acc_done),
    .abort_o   (acc_abort),
    .dm_req_o  (dm_req),
    .dm_we_o   (dm_we),
    .dm_addr_o (dm_addr),
    .dm_wdata_o(dm_wdata),
    .dm_err_o  (dm_err)
  );

  logic               wb_valid_q, wb_valid_d;
  logic [31:0]        do_q, do_d;
  logic [31:0]        alu_q, alu_d;
  logic [RegIdxW-1:0] rw_q, rw_d;
  logic               mtr_q, mtr_d;
  logic               regwr_q, regwr_d;
  logic               trap_q, trap_d;

  always_comb begin
    wb_valid_d = wb_valid_q;
    do_d       = do_q;
    alu_d      = alu_q;
    rw_d       = rw_q;
    mtr_d      = mtr_q;
    regwr_d    = regwr_q;
    trap_d     = 1'b0;
    if (stall || !in_valid) begin
      wb_valid_d = 1'b0;
      regwr_d    = 1'b0;
    end else begin
      wb_valid_d = 1'b1;
      alu_d      = Addr_in;
      rw_d       = Rw_in;
      mtr_d      = MemtoReg;
      regwr_d    = RegWr & ~acc_abort & ~trap;
      trap_d     = trap;
      if (acc_done) begin
        do_d = dm_rdata;
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      do_q       <= '0;
      alu_q      <= '0;
      rw_q       <= '0;
      mtr_q      <= 1'b0;
      regwr_q    <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      do_q       <= do_d;
      alu_q      <= alu_d;
      rw_q       <= rw_d;
      mtr_q      <= mtr_d;
      regwr_q    <= regwr_d;
      trap_q     <= trap_d;
    end
  end

`ifdef MEM_STAGE_OVF_TRAP_EN
  assign ovf_trap = trap_q;
`else
  logic unused_trap_q;
  assign unused_trap_q = trap_q;
`endif

  assign wb_valid     = wb_valid_q;
  assign Do_out       = do_q;
  assign Alu_out      = alu_q;
  assign Rw_out       = rw_q;
  assign MemtoReg_out = mtr_q;
  assign RegWr_out    = regwr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change at posedge, DUT updates at negedge.
module tb_mem_stage;

  logic        clk = 1'b1;
  logic        rst_n = 1'b1;
  logic        in_valid, MemWr, MemtoReg, RegWr, Branch, Jump, Zero, Overflow;
  logic [31:0] Addr_in, Di_in, dm_rdata;
  logic [4:0]  Rw_in;
  logic [29:0] Btarg, Jtarg;
  logic        dm_ready;
  logic        dm_req, dm_we, stall, pc_redirect, dm_err;
  logic [29:0] dm_addr, pc_target;
  logic [31:0] dm_wdata, Do_out, Alu_out;
  logic [4:0]  Rw_out;
  logic        wb_valid, MemtoReg_out, RegWr_out;
`ifdef MEM_STAGE_OVF_TRAP_EN
  logic        ovf_trap;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Addr_in(Addr_in), .Di_in(Di_in),
    .Rw_in(Rw_in), .MemWr(MemWr), .MemtoReg(MemtoReg), .RegWr(RegWr), .Branch(Branch),
    .Jump(Jump), .Zero(Zero), .Overflow(Overflow), .Btarg(Btarg), .Jtarg(Jtarg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .dm_err(dm_err),
`ifdef MEM_STAGE_OVF_TRAP_EN
    .ovf_trap(ovf_trap),
`endif
    .wb_valid(wb_valid), .Do_out(Do_out), .Alu_out(Alu_out), .Rw_out(Rw_out),
    .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out)
  );

  task automatic clear_in();
    in_valid = 0; MemWr = 0; MemtoReg = 0; RegWr = 0; Branch = 0; Jump = 0; Zero = 0;
    Overflow = 0; Addr_in = 0; Di_in = 0; Rw_in = 0; Btarg = 0; Jtarg = 0;
    dm_ready = 0; dm_rdata = 0;
  endtask

  task automatic test_reset();
    clear_in();
    #1 rst_n = 0;
    #2;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %0b want 0", wb_valid); end
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rst_dm_req: got %0b want 0", dm_req); end
    checks++; if (dm_err !== 1'b0 || dm_we !== 1'b0) begin errors++; $display("FAIL rst_dm_err_we: got %0b%0b want 00", dm_err, dm_we); end
    checks++; if (dm_addr !== 30'h0 || dm_wdata !== 32'h0) begin errors++; $display("FAIL rst_dm_bus: got %0h/%0h want 0/0", dm_addr, dm_wdata); end
    checks++; if (Do_out !== 32'h0 || Alu_out !== 32'h0 || Rw_out !== 5'h0) begin errors++; $display("FAIL rst_wb_data: got %0h/%0h/%0h want 0/0/0", Do_out, Alu_out, Rw_out); end
    checks++; if (MemtoReg_out !== 1'b0 || RegWr_out !== 1'b0) begin errors++; $display("FAIL rst_wb_ctl: got %0b%0b want 00", MemtoReg_out, RegWr_out); end
    @(posedge clk);
    rst_n = 1;
  endtask

  task automatic test_alu();
    @(posedge clk);
    in_valid = 1; RegWr = 1; Addr_in = 32'h1234; Rw_in = 5'd7;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", stall); end
    @(posedge clk);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %0b want 1", wb_valid); end
    checks++; if (Alu_out !== 32'h1234 || Rw_out !== 5'd7) begin errors++; $display("FAIL alu_data: got %0h/%0d want 1234/7", Alu_out, Rw_out); end
    checks++; if (RegWr_out !== 1'b1 || MemtoReg_out !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL alu_ctl: got regwr=%0b mtr=%0b req=%0b want 1 0 0", RegWr_out, MemtoReg_out, dm_req); end
    clear_in();
    @(posedge clk);
    checks++; if (wb_valid !== 1'b0 || RegWr_out !== 1'b0) begin errors++; $display("FAIL alu_bubble: got %0b%0b want 00", wb_valid, RegWr_out); end
  endtask

  task automatic test_load();
    int stalls = 0;
    @(posedge clk);
    // MemWr set too: load must win and issue with dm_we=0
    in_valid = 1; MemtoReg = 1; MemWr = 1; RegWr = 1; Addr_in = 32'h100; Rw_in = 5'd3;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dm_ready = 1; dm_rdata = 32'hDEADBEEF; end
      #1;
      if (stall) stalls++;
      @(posedge clk);
      if (i == 0) begin
        checks++; if (dm_req !== 1'b1 || dm_addr !== 30'h40 || dm_we !== 1'b0) begin errors++; $display("FAIL ld_issue: got req=%0b addr=%0h we=%0b want 1 40 0", dm_req, dm_addr, dm_we); end
      end
      if (i < 3) begin
        checks++; if (wb_valid !== 1'b0 || RegWr_out !== 1'b0) begin errors++; $display("FAIL ld_bubble%0d: got %0b%0b want 00", i, wb_valid, RegWr_out); end
      end
    end
    checks++; if (stalls != 3) begin errors++; $display("FAIL ld_stall_cycles: got %0d want 3", stalls); end
    checks++; if (dm_req !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL ld_retire: got req=%0b wbv=%0b want 0 1", dm_req, wb_valid); end
    checks++; if (Do_out !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_do_out: got %0h want deadbeef", Do_out); end
    checks++; if (MemtoReg_out !== 1'b1 || RegWr_out !== 1'b1 || Rw_out !== 5'd3 || Alu_out !== 32'h100) begin errors++; $display("FAIL ld_wb_ctl: got mtr=%0b rw=%0b rd=%0d alu=%0h want 1 1 3 100", MemtoReg_out, RegWr_out, Rw_out, Alu_out); end
    clear_in();
  endtask

  task automatic test_store();
    int reqs = 0;
    @(posedge clk);
    in_valid = 1; MemWr = 1; Addr_in = 32'h200; Di_in = 32'hA5A5A5A5; Rw_in = 5'd1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_stall0: got %0b want 1", stall); end
    @(posedge clk);
    if (dm_req) reqs++;
    checks++; if (dm_we !== 1'b1 || dm_wdata !== 32'hA5A5A5A5 || dm_addr !== 30'h80) begin errors++; $display("FAIL st_issue: got we=%0b data=%0h addr=%0h want 1 a5a5a5a5 80", dm_we, dm_wdata, dm_addr); end
    dm_ready = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st_stall1: got %0b want 0", stall); end
    @(posedge clk);
    if (dm_req) reqs++;
    checks++; if (wb_valid !== 1'b1 || RegWr_out !== 1'b0 || Alu_out !== 32'h200) begin errors++; $display("FAIL st_retire: got wbv=%0b rw=%0b alu=%0h want 1 0 200", wb_valid, RegWr_out, Alu_out); end
    // ready held high while idle must be ignored
    in_valid = 0; MemWr = 0;
    @(posedge clk);
    if (dm_req) reqs++;
    checks++; if (reqs != 1) begin errors++; $display("FAIL st_req_pulse: got %0d want 1", reqs); end
    checks++; if (wb_valid !== 1'b0 || dm_err !== 1'b0) begin errors++; $display("FAIL st_idle_ready: got wbv=%0b err=%0b want 0 0", wb_valid, dm_err); end
    clear_in();
  endtask

  task automatic test_redirect();
    @(posedge clk);
    in_valid = 1; Branch = 1; Zero = 1; Btarg = 30'h100; Jtarg = 30'h2000;
    #1;
    checks++; if (pc_redirect !== 1'b1 || pc_target !== 30'h100) begin errors++; $display("FAIL br_taken: got %0b/%0h want 1/100", pc_redirect, pc_target); end
    Zero = 0;
    #1;
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL br_not_taken: got %0b want 0", pc_redirect); end
    Zero = 1; Jump = 1;
    #1;
    checks++; if (pc_redirect !== 1'b1 || pc_target !== 30'h2000) begin errors++; $display("FAIL jump_wins: got %0b/%0h want 1/2000", pc_redirect, pc_target); end
    @(posedge clk);
    in_valid = 0;
    #1;
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL redirect_invalid: got %0b want 0", pc_redirect); end
    clear_in();
  endtask

  task automatic test_timeout();
    int reqs = 0;
    bit released = 0;
    @(posedge clk);
    in_valid = 1; MemtoReg = 1; RegWr = 1; Addr_in = 32'h300; Rw_in = 5'd9;
    for (int i = 0; i < 20 && !released; i++) begin
      #1;
      if (!stall) released = 1;
      @(posedge clk);
      if (dm_req) reqs++;
    end
    checks++; if (!released) begin errors++; $display("FAIL to_release: got stall stuck want released"); end
    checks++; if (reqs != 5) begin errors++; $display("FAIL to_req_edges: got %0d want 5", reqs); end
    checks++; if (dm_err !== 1'b1 || dm_req !== 1'b0) begin errors++; $display("FAIL to_abort: got err=%0b req=%0b want 1 0", dm_err, dm_req); end
    checks++; if (wb_valid !== 1'b1 || RegWr_out !== 1'b0) begin errors++; $display("FAIL to_retire: got wbv=%0b rw=%0b want 1 0", wb_valid, RegWr_out); end
    clear_in();
    @(posedge clk);
    checks++; if (dm_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %0b want 0", dm_err); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    in_valid = 1; MemtoReg = 1; RegWr = 1; Addr_in = 32'h400; Rw_in = 5'd4;
    @(posedge clk);
    checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rm_req_up: got %0b want 1", dm_req); end
    #2 rst_n = 0;
    #1;
    checks++; if (dm_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rm_async: got req=%0b wbv=%0b want 0 0", dm_req, wb_valid); end
    clear_in();
    @(posedge clk);
    rst_n = 1;
    in_valid = 1; RegWr = 1; Addr_in = 32'h55; Rw_in = 5'd2;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_idle_stall: got %0b want 0", stall); end
    @(posedge clk);
    checks++; if (wb_valid !== 1'b1 || Alu_out !== 32'h55 || dm_req !== 1'b0) begin errors++; $display("FAIL rm_idle_retire: got wbv=%0b alu=%0h req=%0b want 1 55 0", wb_valid, Alu_out, dm_req); end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_redirect();
    test_timeout();
    test_reset_mid();
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
